// File: rtl/multiword_add_ctrl.sv
// multiword_add_ctrl
//   Performs a CHUNK*NCHUNK-bit add by running one CHUNK-bit ripple-carry adder
//   (verilogtest_03) over NCHUNK cycles. Chunks are processed LSB-first, and a
//   register carries the result from one chunk to the next.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   start  request, sampled only in IDLE
//   a, b   TW-bit operands, captured when start is accepted
//   cin    carry-in, captured when start is accepted
//   busy   high in RUN and DONE
//   done   one-cycle pulse; sum/cout are valid
//   sum    TW-bit result, held until the next accepted start overwrites it
//   cout   final carry-out, held with sum

// verilogtest_03
//   Parameterized combinational ripple-carry adder.
// Ports:
//   A, B  N-bit addends
//   Cin   carry-in
//   Sum   N-bit sum
//   Cout  carry-out
module verilogtest_03 #(
  parameter int N = 8
) (
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cin,
  output logic [N-1:0] Sum,
  output logic         Cout
);

  logic w_c;

  always_comb begin
    w_c = Cin;
    Sum = '0;
    for (int unsigned i = 0; i < N; i++) begin
      Sum[i] = A[i] ^ B[i] ^ w_c;
      w_c    = (A[i] & B[i]) | (w_c & (A[i] ^ B[i]));
    end
    Cout = w_c;
  end

endmodule

module multiword_add_ctrl #(
  parameter int CHUNK  = 8,
  parameter int NCHUNK = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [CHUNK*NCHUNK-1:0]   a,
  input  logic [CHUNK*NCHUNK-1:0]   b,
  input  logic                      cin,
  output logic                      busy,
  output logic                      done,
  output logic [CHUNK*NCHUNK-1:0]   sum,
  output logic                      cout
);

  localparam int TW = CHUNK * NCHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       r_state;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic [TW-1:0]    r_a;
  logic [TW-1:0]    r_b;
  logic [TW-1:0]    r_sum;
  logic             r_cout;

  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK-1:0] w_sum_chunk;
  logic             w_cout;

  assign w_a_chunk = r_a[r_idx*CHUNK +: CHUNK];
  assign w_b_chunk = r_b[r_idx*CHUNK +: CHUNK];

  verilogtest_03 #(.N(CHUNK)) u_add (
    .A    (w_a_chunk),
    .B    (w_b_chunk),
    .Cin  (r_carry),
    .Sum  (w_sum_chunk),
    .Cout (w_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_sum[r_idx*CHUNK +: CHUNK] <= w_sum_chunk;
          r_carry <= w_cout;
          if (r_idx == LAST) begin
            // idx wraps to 0 so it never leaves 0..NCHUNK-1
            r_idx   <= '0;
            r_cout  <= w_cout;
            r_state <= DONE;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy = (r_state == RUN) || (r_state == DONE);
  assign done = (r_state == DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: doc/multiword_add_ctrl.md
Name: multiword_add_ctrl

Overview:
Sequencer that performs a wide add (CHUNK*NCHUNK bits) by reusing one CHUNK-bit instance of the team's parameterized ripple-carry adder (verilogtest_03 #(CHUNK)) over NCHUNK clock cycles.
- Operand chunks are processed LSB-first.
- Carry passes between chunks through a register.
- Trades latency for area wherever a wide adder is too costly.
- Sits between a requester (start/done handshake) and the shared adder datapath.

Parameters:
CHUNK, 8, width in bits of the single adder instance (>=1)
NCHUNK, 4, number of chunks per operation (>=1); total width TW = CHUNK*NCHUNK

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous reset, active-low
start  input  1  request; sampled only in IDLE
a  input  TW  operand A, captured when start is accepted
b  input  TW  operand B, captured when start is accepted
cin  input  1  carry-in, captured when start is accepted
busy  output  1  high while an operation is in progress (RUN or DONE)
done  output  1  one-cycle pulse; sum/cout are valid
sum  output  TW  result, held from done until the next accepted start
cout  output  1  final carry-out, held with sum

Behaviour:
- Clocking and reset:
  - Single clock.
  - Reset is synchronous and active-low.
  - While rst_n=0 at a rising edge: state=IDLE, busy=0, done=0, sum=0, cout=0, chunk index=0, carry reg=0, operand regs=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE: start=1 at an edge latches a, b, cin into internal regs, sets idx=0, carry=cin, and goes to RUN. sum and cout keep their previous values until overwritten.
  - RUN: the adder sees A=a_reg[idx*CHUNK +: CHUNK], B=b_reg[idx*CHUNK +: CHUNK], Cin=carry. At each edge:
    - sum[idx*CHUNK +: CHUNK] <= adder Sum
    - carry <= adder Cout
    - idx <= idx+1
    - when idx==NCHUNK-1: cout <= adder Cout and go to DONE
  - DONE: done=1 and busy=1 for exactly this one cycle; unconditional return to IDLE on the next edge.
- Latency:
  - The edge accepting start is E0.
  - RUN occupies edges E1..E_NCHUNK.
  - done is high during the cycle after edge E_NCHUNK.
  - Next start can be accepted at the edge ending the DONE cycle+1 (i.e., in IDLE).
  - NCHUNK=1 → done one cycle after the single RUN cycle.
- Arithmetic:
  - Unsigned modulo 2^TW; {cout,sum} = a + b + cin exactly.
  - Carry crosses chunk boundaries only through the carry register, never combinationally.
- Handshake rules:
  - start is ignored in RUN and DONE; no queuing, no abort.
  - A new start in IDLE the cycle after DONE is accepted normally.
  - Operand inputs may change freely after acceptance; they have no effect on the result in flight.
- sum bits above the current idx hold stale (previous-result) values during RUN. They are valid only once done is asserted.
- Reset mid-operation: the operation is dropped and no done is produced. All outputs clear at the reset edge, and the block resumes in IDLE.
- Simultaneous rst_n=0 and start=1: reset wins; start is not captured.
- idx is sized $clog2(NCHUNK) bits, minimum 1; it never exceeds NCHUNK-1.

Test Plan:
1. CHUNK=8,NCHUNK=4: a=32'h0000000A, b=32'h0000000C, cin=1, pulse start → busy for 5 cycles; done exactly 5 edges after E0; sum=32'h00000017, cout=0.
2. Full carry ripple: a=32'hFFFFFFFF, b=0, cin=1 → sum=32'h00000000, cout=1. Also a=32'h80000000, b=32'h80000000, cin=0 → sum=0, cout=1.
3. Chunk boundary: a=32'h000000FF, b=32'h00000001, cin=0 → sum=32'h00000100, cout=0. Also a=32'h00FFFFFF, b=1 → sum=32'h01000000.
4. Start while busy: accept a=5, b=7. Assert start with a=100, b=200 during RUN cycle 2 and again during DONE → single done pulse, sum=12. Block returns to IDLE and the next start with a=100, b=200 yields 300.
5. Reset mid-op: start a=32'h12345678, b=32'h11111111; drop rst_n for one edge during RUN (idx=2) → next cycle busy=0, done=0, sum=0, cout=0, and no done follows. A new start then gives sum=32'h23456789.
6. Parameter sweep: CHUNK=16,NCHUNK=1 with a=16'hFFFF, b=16'h0001, cin=0 → sum=0, cout=1, done 2 edges after E0. Back-to-back starts give one result per 3 cycles.
